// File: rtl/cpu_pkg.sv
// Shared CPU definitions: byte-enable encodings for sub-word memory accesses
// and the word-granular address type used by the LL/SC reservation.
package cpu_pkg;

    localparam int CPU_BITS = 32;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_B0      = 4'b0001;
    localparam logic [3:0] BE_B1      = 4'b0010;
    localparam logic [3:0] BE_B2      = 4'b0100;
    localparam logic [3:0] BE_B3      = 4'b1000;

    // Reservations track whole words, so the two byte-offset bits are dropped.
    typedef logic [CPU_BITS-3:0] link_addr_t;

    function automatic link_addr_t word_addr(input logic [CPU_BITS-1:0] byte_addr);
        return byte_addr[CPU_BITS-1:2];
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: extracts the addressed byte or halfword from the memory
// read word and zero-extends it; unrecognised lane patterns return the word.
module load_align
    import cpu_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] mem_rdata_i,
    input  logic [3:0]      byte_en_i,
    output logic [BITS-1:0] aligned_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives aligned_o; no latch is inferred.
        aligned_o = mem_rdata_i;
        case (byte_en_i)
            BE_WORD:    aligned_o = mem_rdata_i;
            BE_HALF_LO: aligned_o = {{(BITS-16){1'b0}}, mem_rdata_i[15:0]};
            BE_HALF_HI: aligned_o = {{(BITS-16){1'b0}}, mem_rdata_i[31:16]};
            BE_B0:      aligned_o = {{(BITS-8){1'b0}},  mem_rdata_i[7:0]};
            BE_B1:      aligned_o = {{(BITS-8){1'b0}},  mem_rdata_i[15:8]};
            BE_B2:      aligned_o = {{(BITS-8){1'b0}},  mem_rdata_i[23:16]};
            BE_B3:      aligned_o = {{(BITS-8){1'b0}},  mem_rdata_i[31:24]};
            default:    aligned_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback (S5) stage: writeback mux and register-file write port, LL/SC
// reservation, sticky halt latch and saturating retired-instruction counter.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int BITS      = CPU_BITS,
    parameter int REG_WORDS = 32,
    parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
    parameter int CNT_BITS  = 32
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                valid_s5,
    input  logic                rw_s5,
    input  logic [ADDR_LEFT:0]  waddr_s5,
    input  logic                sel_mem_s5,
    input  logic                mem_rw_s5,
    input  logic                atomic_s5,
    input  logic                load_link_s5,
    input  logic                check_link_s5,
    input  logic [3:0]          byte_en_s5,
    input  logic                halt_s5,
    input  logic [BITS-1:0]     alu_out_s5,
    input  logic [BITS-1:0]     mem_rdata_s5,
    output logic                rf_we,
    output logic [ADDR_LEFT:0]  rf_waddr,
    output logic [BITS-1:0]     rf_wdata,
    output logic                sc_success,
    output logic                link_valid,
    output logic                halted,
    output logic [CNT_BITS-1:0] retired_cnt
);

    logic                link_valid_q, link_valid_d;
    link_addr_t          link_addr_q,  link_addr_d;
    logic                halted_q,     halted_d;
    logic [CNT_BITS-1:0] retired_cnt_q, retired_cnt_d;

    logic            live;
    logic            is_ll;
    logic            is_sc;
    logic            is_store;
    logic            addr_match;
    logic [BITS-1:0] load_data;

    load_align #(
        .BITS (BITS)
    ) u_load_align (
        .mem_rdata_i (mem_rdata_s5),
        .byte_en_i   (byte_en_s5),
        .aligned_o   (load_data)
    );

    // SC wins when both atomic flavours are flagged, so LL is masked by SC.
    assign live       = valid_s5 & ~halted_q;
    assign is_sc      = live & atomic_s5 & check_link_s5;
    assign is_ll      = live & atomic_s5 & load_link_s5 & ~check_link_s5;
    assign is_store   = live & mem_rw_s5 & ~atomic_s5;
    assign addr_match = (link_addr_q == word_addr(alu_out_s5));

    assign sc_success = is_sc & link_valid_q & addr_match;
    assign rf_we      = live & rw_s5 & (waddr_s5 != '0);
    assign rf_waddr   = waddr_s5;
    assign link_valid = link_valid_q;
    assign halted     = halted_q;
    assign retired_cnt = retired_cnt_q;

    always_comb begin
        rf_wdata = alu_out_s5;
        if (is_sc) begin
            rf_wdata = {{(BITS-1){1'b0}}, sc_success};
        end else if (is_ll || sel_mem_s5) begin
            rf_wdata = load_data;
        end
    end

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (is_sc) begin
            link_valid_d = 1'b0;
        end else if (is_ll) begin
            link_valid_d = 1'b1;
            link_addr_d  = word_addr(alu_out_s5);
        end else if (is_store && addr_match) begin
            link_valid_d = 1'b0;
        end
    end

    always_comb begin
        halted_d      = halted_q | (live & halt_s5);
        retired_cnt_d = retired_cnt_q;
        if (live && (retired_cnt_q != {CNT_BITS{1'b1}})) begin
            retired_cnt_d = retired_cnt_q + CNT_BITS'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            link_valid_q  <= 1'b0;
            link_addr_q   <= '0;
            halted_q      <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            link_valid_q  <= link_valid_d;
            link_addr_q   <= link_addr_d;
            halted_q      <= halted_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writeback results are queued as each
// instruction is driven and compared when the stage presents its outputs.
module tb_wb_stage;

    localparam int BITS = 32;
    localparam int CNT  = 4;

    logic            clk = 1'b0;
    logic            rst_;
    logic            valid_s5, rw_s5, sel_mem_s5, mem_rw_s5;
    logic            atomic_s5, load_link_s5, check_link_s5, halt_s5;
    logic [4:0]      waddr_s5;
    logic [3:0]      byte_en_s5;
    logic [BITS-1:0] alu_out_s5, mem_rdata_s5;
    logic            rf_we, sc_success, link_valid, halted;
    logic [4:0]      rf_waddr;
    logic [BITS-1:0] rf_wdata;
    logic [CNT-1:0]  retired_cnt;

    typedef struct {
        string       tag;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        sc;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic [CNT-1:0] exp_cnt    = '0;
    logic           exp_halted = 1'b0;

    wb_stage #(
        .BITS      (BITS),
        .REG_WORDS (32),
        .CNT_BITS  (CNT)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .valid_s5      (valid_s5),
        .rw_s5         (rw_s5),
        .waddr_s5      (waddr_s5),
        .sel_mem_s5    (sel_mem_s5),
        .mem_rw_s5     (mem_rw_s5),
        .atomic_s5     (atomic_s5),
        .load_link_s5  (load_link_s5),
        .check_link_s5 (check_link_s5),
        .byte_en_s5    (byte_en_s5),
        .halt_s5       (halt_s5),
        .alu_out_s5    (alu_out_s5),
        .mem_rdata_s5  (mem_rdata_s5),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .sc_success    (sc_success),
        .link_valid    (link_valid),
        .halted        (halted),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        valid_s5 = 0; rw_s5 = 0; waddr_s5 = '0; sel_mem_s5 = 0; mem_rw_s5 = 0;
        atomic_s5 = 0; load_link_s5 = 0; check_link_s5 = 0; byte_en_s5 = '0;
        halt_s5 = 0; alu_out_s5 = '0; mem_rdata_s5 = '0;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] wa,
                         input logic sm, input logic mw, input logic at,
                         input logic ll, input logic sc, input logic [3:0] be,
                         input logic h, input logic [31:0] alu, input logic [31:0] rd);
        valid_s5 = v; rw_s5 = rw; waddr_s5 = wa; sel_mem_s5 = sm; mem_rw_s5 = mw;
        atomic_s5 = at; load_link_s5 = ll; check_link_s5 = sc; byte_en_s5 = be;
        halt_s5 = h; alu_out_s5 = alu; mem_rdata_s5 = rd;
    endtask

    task automatic expect_wb(input string tag, input logic we, input logic [31:0] wdata,
                             input logic sc);
        exp_t e;
        e.tag = tag; e.we = we; e.waddr = waddr_s5; e.wdata = wdata; e.sc = sc;
        sb.push_back(e);
    endtask

    // Compare the queued result mid-cycle, then clock it in and check state.
    task automatic run();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".we"}, 32'(rf_we), 32'(e.we));
            check({e.tag, ".waddr"}, 32'(rf_waddr), 32'(e.waddr));
            check({e.tag, ".sc"}, 32'(sc_success), 32'(e.sc));
            if (e.we) check({e.tag, ".wdata"}, rf_wdata, e.wdata);
        end
        @(posedge clk);
        #1;
        if (valid_s5 && !exp_halted) begin
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            if (halt_s5) exp_halted = 1'b1;
        end
        check({e.tag, ".cnt"}, 32'(retired_cnt), 32'(exp_cnt));
        check({e.tag, ".halted"}, 32'(halted), 32'(exp_halted));
    endtask

    initial begin
        idle();
        rst_ = 1'b0;
        #12;
        check("rst.we", 32'(rf_we), 0);
        check("rst.wdata", rf_wdata, 0);
        check("rst.sc", 32'(sc_success), 0);
        check("rst.link", 32'(link_valid), 0);
        check("rst.halted", 32'(halted), 0);
        check("rst.cnt", 32'(retired_cnt), 0);
        rst_ = 1'b1;
        @(posedge clk); #1;

        // ALU writeback
        drive(1,1,5'd5,0,0,0,0,0,4'b1111,0,32'h1234,32'h0);
        expect_wb("alu", 1, 32'h1234, 0); run();

        // Load alignment of 0xAABBCCDD across lane patterns
        drive(1,1,5'd9,1,0,0,0,0,4'b0100,0,32'h0,32'hAABBCCDD); expect_wb("ld_b2", 1, 32'hBB, 0); run();
        drive(1,1,5'd9,1,0,0,0,0,4'b1100,0,32'h0,32'hAABBCCDD); expect_wb("ld_hhi", 1, 32'hAABB, 0); run();
        drive(1,1,5'd9,1,0,0,0,0,4'b1111,0,32'h0,32'hAABBCCDD); expect_wb("ld_word", 1, 32'hAABBCCDD, 0); run();
        drive(1,1,5'd9,1,0,0,0,0,4'b0001,0,32'h0,32'hAABBCCDD); expect_wb("ld_b0", 1, 32'hDD, 0); run();
        drive(1,1,5'd9,1,0,0,0,0,4'b0010,0,32'h0,32'hAABBCCDD); expect_wb("ld_b1", 1, 32'hCC, 0); run();
        drive(1,1,5'd9,1,0,0,0,0,4'b1000,0,32'h0,32'hAABBCCDD); expect_wb("ld_b3", 1, 32'hAA, 0); run();
        drive(1,1,5'd9,1,0,0,0,0,4'b0011,0,32'h0,32'hAABBCCDD); expect_wb("ld_hlo", 1, 32'hCCDD, 0); run();
        drive(1,1,5'd9,1,0,0,0,0,4'b0110,0,32'h0,32'hAABBCCDD); expect_wb("ld_odd", 1, 32'hAABBCCDD, 0); run();

        // r0 is never written but the instruction still retires
        drive(1,1,5'd0,0,0,0,0,0,4'b1111,0,32'h55,32'h0);
        expect_wb("r0", 0, 32'h55, 0); run();

        // LL / SC to the same word
        drive(1,1,5'd3,1,0,1,1,0,4'b1111,0,32'h100,32'h12345678);
        expect_wb("ll1", 1, 32'h12345678, 0); run();
        check("ll1.link", 32'(link_valid), 1);
        drive(1,1,5'd4,0,1,1,0,1,4'b1111,0,32'h100,32'h0);
        expect_wb("sc1", 1, 32'h1, 1); run();
        check("sc1.link", 32'(link_valid), 0);

        // Store into the reserved word kills the reservation
        drive(1,1,5'd3,1,0,1,1,0,4'b1111,0,32'h100,32'h0); expect_wb("ll2", 1, 32'h0, 0); run();
        drive(1,0,5'd0,0,1,0,0,0,4'b0011,0,32'h102,32'h0); expect_wb("st_hit", 0, 32'h0, 0); run();
        check("st_hit.link", 32'(link_valid), 0);
        drive(1,1,5'd4,0,1,1,0,1,4'b1111,0,32'h100,32'h0); expect_wb("sc2", 1, 32'h0, 0); run();

        // Store elsewhere leaves it; a second SC fails
        drive(1,1,5'd3,1,0,1,1,0,4'b1111,0,32'h100,32'h0); expect_wb("ll3", 1, 32'h0, 0); run();
        drive(1,0,5'd0,0,1,0,0,0,4'b1111,0,32'h200,32'h0); expect_wb("st_miss", 0, 32'h0, 0); run();
        check("st_miss.link", 32'(link_valid), 1);
        drive(1,1,5'd4,0,1,1,0,1,4'b1111,0,32'h100,32'h0); expect_wb("sc3", 1, 32'h1, 1); run();
        drive(1,1,5'd4,0,1,1,0,1,4'b1111,0,32'h100,32'h0); expect_wb("sc4", 1, 32'h0, 0); run();

        // LL and SC together: SC checks and clears, no new reservation
        drive(1,1,5'd3,1,0,1,1,0,4'b1111,0,32'h300,32'h0); expect_wb("ll4", 1, 32'h0, 0); run();
        drive(1,1,5'd4,1,1,1,1,1,4'b1111,0,32'h300,32'h0); expect_wb("llsc", 1, 32'h1, 1); run();
        check("llsc.link", 32'(link_valid), 0);

        // A second LL overwrites the reservation address
        drive(1,1,5'd3,1,0,1,1,0,4'b1111,0,32'h100,32'h0); expect_wb("ll5", 1, 32'h0, 0); run();
        drive(1,1,5'd3,1,0,1,1,0,4'b1111,0,32'h400,32'h0); expect_wb("ll6", 1, 32'h0, 0); run();
        drive(1,1,5'd4,0,1,1,0,1,4'b1111,0,32'h100,32'h0); expect_wb("sc5", 1, 32'h0, 0); run();

        // Bubble does nothing
        drive(0,1,5'd6,0,0,0,0,0,4'b1111,0,32'h66,32'h0); expect_wb("bubble", 0, 32'h0, 0); run();

        // Halt retires and writes, then everything freezes
        drive(1,1,5'd2,1,0,1,1,0,4'b1111,0,32'h500,32'h0); expect_wb("ll7", 1, 32'h0, 0); run();
        drive(1,1,5'd7,0,0,0,0,0,4'b1111,1,32'h77,32'h0); expect_wb("halt", 1, 32'h77, 0); run();
        drive(1,1,5'd8,0,0,0,0,0,4'b1111,0,32'h88,32'h0); expect_wb("post_halt", 0, 32'h0, 0); run();
        drive(1,1,5'd4,0,1,1,0,1,4'b1111,0,32'h500,32'h0); expect_wb("sc_halted", 0, 32'h0, 0); run();
        check("halted.link", 32'(link_valid), 1);

        // Asynchronous reset away from any clock edge
        idle();
        #2;
        rst_ = 1'b0;
        #1;
        check("arst.halted", 32'(halted), 0);
        check("arst.link", 32'(link_valid), 0);
        check("arst.cnt", 32'(retired_cnt), 0);
        exp_cnt = '0;
        exp_halted = 1'b0;
        #3;
        rst_ = 1'b1;
        @(posedge clk); #1;
        drive(1,1,5'd5,0,0,0,0,0,4'b1111,0,32'hBEEF,32'h0);
        expect_wb("after_rst", 1, 32'hBEEF, 0); run();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
